// File: rtl/ahb3_pkg.sv
// Shared AHB3-lite constants, request record and alignment helper for the
// single-transfer master.
package ahb3_pkg;

  localparam int AHB3_ADDR_W = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  // addr is AHB3_ADDR_W wide; the master's ADDR_W is expected to match it
  typedef struct packed {
    logic [AHB3_ADDR_W-1:0] addr;
    logic                   write;
    logic [2:0]             size;
    logic [31:0]            wdata;
  } ahb3_req_t;

  // 1 when the size code is illegal or the address is not naturally aligned
  function automatic logic req_misaligned(input logic [1:0] addr_lsb, input logic [2:0] size);
    logic bad;
    case (size)
      HSIZE_BYTE: bad = 1'b0;
      HSIZE_HALF: bad = addr_lsb[0];
      HSIZE_WORD: bad = (addr_lsb != 2'b00);
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ahb3_lite_master_if.sv
// AHB3-lite bus bundle between the single-transfer master and a slave.
interface ahb3_lite_master_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] HADDR_o;
  logic              HWRITE_o;
  logic [2:0]        HSIZE_o;
  logic [2:0]        HBURST_o;
  logic [3:0]        HPROT_o;
  logic [1:0]        HTRANS_o;
  logic              HMASTLOCK_o;
  logic [31:0]       HWDATA_o;
  logic              HREADY_i;
  logic              HRESP_i;
  logic [31:0]       HRDATA_i;

  modport master (
    output HADDR_o, HWRITE_o, HSIZE_o, HBURST_o, HPROT_o, HTRANS_o,
           HMASTLOCK_o, HWDATA_o,
    input  HREADY_i, HRESP_i, HRDATA_i
  );

  modport slave (
    input  HADDR_o, HWRITE_o, HSIZE_o, HBURST_o, HPROT_o, HTRANS_o,
           HMASTLOCK_o, HWDATA_o,
    output HREADY_i, HRESP_i, HRDATA_i
  );
endinterface

// File: rtl/ahb3_lite_master.sv
// AHB3-lite single-transfer master: valid/ready requests -> NONSEQ/SINGLE transfers.
// Optional build macro AHB3_MASTER_ALIGN_CHECK_EN completes misaligned/illegal requests locally with an error.
module ahb3_lite_master
  import ahb3_pkg::*;
#(
  parameter int         ADDR_W    = AHB3_ADDR_W,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic [2:0]        req_size,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  ahb3_lite_master_if.master bus
);

  ahb3_req_t   req_s;
  ahb3_req_t   a_r;
  logic        a_valid_r;
  logic        a_lerr_r;
  logic        d_valid_r;
  logic        d_write_r;
  logic        d_lerr_r;
  logic [31:0] d_wdata_r;
  logic        rsp_valid_r;
  logic        rsp_err_r;
  logic [31:0] rsp_rdata_r;

  logic        err_first_s;
  logic        advance_s;
  logic        issue_s;
  logic        ready_s;
  logic        load_s;
  logic        req_lerr_s;

  // Handshake, pipeline advance and bus-issue decisions
  always_comb begin
    req_s       = '0;
    req_s.addr  = req_addr;
    req_s.write = req_write;
    req_s.size  = req_size;
    req_s.wdata = req_wdata;
`ifdef AHB3_MASTER_ALIGN_CHECK_EN
    req_lerr_s  = req_misaligned(req_addr[1:0], req_size);
`else
    req_lerr_s  = 1'b0;
`endif
    // first ERROR cycle: local errors never drew a slave response
    err_first_s = d_valid_r && !d_lerr_r && bus.HRESP_i && !bus.HREADY_i;
    advance_s   = bus.HREADY_i;
    issue_s     = a_valid_r && !a_lerr_r && !err_first_s;
    ready_s     = !reset && (!a_valid_r || (bus.HREADY_i && !err_first_s));
    load_s      = req_valid && ready_s;
  end

  // Address stage: loads on accept, empties when its address phase is taken
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_valid_r <= 1'b0;
      a_r       <= '0;
      a_lerr_r  <= 1'b0;
    end else if (load_s) begin
      a_valid_r <= 1'b1;
      a_r       <= req_s;
      a_lerr_r  <= req_lerr_s;
    end else if (advance_s) begin
      a_valid_r <= 1'b0;
    end
  end

  // Data stage: takes over the address stage on every HREADY edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_valid_r <= 1'b0;
      d_write_r <= 1'b0;
      d_lerr_r  <= 1'b0;
      d_wdata_r <= 32'h0000_0000;
    end else if (advance_s) begin
      d_valid_r <= a_valid_r;
      d_write_r <= a_r.write;
      d_lerr_r  <= a_lerr_r;
      d_wdata_r <= a_r.wdata;
    end
  end

  // Completion pulse with read data and error status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
    end else if (advance_s && d_valid_r) begin
      rsp_valid_r <= 1'b1;
      rsp_err_r   <= d_lerr_r || bus.HRESP_i;
      rsp_rdata_r <= (d_write_r || d_lerr_r || bus.HRESP_i) ? 32'h0000_0000 : bus.HRDATA_i;
    end else begin
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
    end
  end

  assign req_ready = ready_s;
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_rdata = rsp_rdata_r;

  assign bus.HTRANS_o    = issue_s ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.HADDR_o     = a_r.addr;
  assign bus.HWRITE_o    = a_r.write;
  assign bus.HSIZE_o     = a_r.size;
  assign bus.HBURST_o    = HBURST_SINGLE;
  assign bus.HPROT_o     = HPROT_VAL;
  assign bus.HMASTLOCK_o = 1'b0;
  assign bus.HWDATA_o    = d_wdata_r;

endmodule

// File: doc/ahb3_lite_master.md
Name: ahb3_lite_master

Overview:
- AHB-lite single-transfer master driving a bus slave such as a bench memory model or an on-chip SRAM bridge.
- Converts a simple valid/ready request stream from a core or DMA agent into NONSEQ/SINGLE transfers.
- Address phase of transfer N+1 overlaps data phase of transfer N.
- Returns one response per accepted request, carrying read data and error status.

Parameters:
- ADDR_W, 32, width of HADDR and req_addr.
- HPROT_VAL, 4'b0011, constant HPROT driven on every transfer (data, privileged).

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready at clk edge
- req_addr  in  ADDR_W  byte address
- req_write  in  1  1=write, 0=read
- req_size  in  3  HSIZE encoding: 0=byte, 1=half, 2=word; 3-7 illegal
- req_wdata  in  32  write data, already lane-aligned by requester
- rsp_valid  out  1  single-cycle response pulse, no backpressure
- rsp_rdata  out  32  read data; 0 for writes and errors
- rsp_err  out  1  transfer completed with ERROR
- HADDR_o  out  ADDR_W
- HWRITE_o  out  1
- HSIZE_o  out  3
- HBURST_o  out  3  constant SINGLE (3'b000)
- HPROT_o  out  4  constant HPROT_VAL
- HTRANS_o  out  2  IDLE or NONSEQ only
- HMASTLOCK_o  out  1  constant 0
- HWDATA_o  out  32  driven during data phase
- HREADY_i  in  1
- HRESP_i  in  1
- HRDATA_i  in  32

Behaviour:
- Two stages:
  - A-stage: address phase holding addr, write, size, wdata.
  - D-stage: data phase holding write, wdata.
- Reset (asynchronous, immediate):
  - A-stage and D-stage invalid; HTRANS_o=IDLE; HADDR_o=0; HWRITE_o=0; HSIZE_o=0; HWDATA_o=0.
  - rsp_valid=0; rsp_rdata=0; rsp_err=0; req_ready=0 while reset is asserted.
  - In-flight transfers are dropped; no response is issued for them.
- req_ready = !A_valid || (HREADY_i && !err_first), where err_first = D_valid && HRESP_i && !HREADY_i.
  - Request loads the A-stage in the same cycle the old A content moves to the D-stage.
- HTRANS_o = NONSEQ when A_valid && !err_first, else IDLE. HADDR_o, HWRITE_o and HSIZE_o are sourced from the A-stage.
  - While HREADY_i=0 and no error, the address-phase signals are held stable.
- On a clk edge with HREADY_i=1:
  - A content (if valid) moves to the D-stage.
  - The D-stage transfer completes.
  - HWDATA_o = D.wdata throughout the data phase; it does not change while HREADY_i=0.
- Completion: rsp_valid=1 for one cycle in the cycle after the HREADY_i=1 edge.
  - rsp_rdata = HRDATA_i sampled at that edge for reads; 0 for writes.
  - rsp_err = HRESP_i sampled at that edge.
- Error handling (two-cycle ERROR response):
  - Cycle 1 (HRESP_i=1, HREADY_i=0): HTRANS_o forced IDLE; the pending A-stage is kept, not cancelled.
  - Cycle 2 (HRESP_i=1, HREADY_i=1): D completes with rsp_err=1.
  - The A-stage re-issues as NONSEQ in the following cycle. Latency is one extra cycle; no request is lost.
- Latency:
  - Minimum request-accept to rsp_valid is 2 cycles: accept edge, address phase, data-phase edge, then rsp.
  - Peak throughput is one transfer per cycle when the slave is zero-wait.
- Simultaneous request accept and completion in the same cycle are both legal.
- Ordering: responses are returned strictly in request order.
- Illegal req_size (3-7): forwarded to the bus unchanged, unless the optional feature below is enabled.

Optional Feature:
- Macro: AHB3_MASTER_ALIGN_CHECK_EN.
- With the macro defined:
  - A request with misaligned addr (half with addr[0]=1; word with addr[1:0]!=0) or req_size>2 is accepted but never put on the bus.
  - It enters the D-stage as a "local error" with HTRANS_o=IDLE for its address phase.
  - It completes in order with rsp_err=1 and rsp_rdata=0, with the same timing as a zero-wait transfer.
- Without the macro: there is no check and all requests are issued.

Decomposition:
- Package ahb3_pkg holds:
  - HTRANS constants: IDLE, BUSY, NONSEQ, SEQ.
  - HSIZE constants: BYTE, HALF, WORD.
  - HBURST constant: SINGLE.
  - Packed struct ahb3_req_t with addr, write, size, wdata, used for both stages.
- No sub-module: both stages and the response logic form a single module, roughly 150-250 lines.

Test Plan:
- Zero-wait memory slave: write 0xDEADBEEF to 0x10, then read 0x10 back-to-back → HTRANS NONSEQ on two consecutive cycles; read rsp_rdata=0xDEADBEEF; rsp_err=0; responses arrive 2 cycles after each accept.
- Slave inserts 3 wait states on a read of 0x20 while a write to 0x24 is queued → HADDR_o holds 0x24 and HWDATA_o stays stable for 3 cycles; req_ready=0; exactly two rsp pulses, in order.
- Slave returns ERROR on a read of 0x30 with a read of 0x34 pending → HTRANS_o=IDLE in the first error cycle; rsp_err=1, rsp_rdata=0 for 0x30; 0x34 re-issued next cycle and completes with rsp_err=0.
- Reset asserted mid-data-phase of a write to 0x40 → outputs go to reset values immediately; no rsp_valid; after release, a read of 0x40 works normally.
- With AHB3_MASTER_ALIGN_CHECK_EN defined: word read at 0x42 → no NONSEQ on the bus, rsp_err=1 two cycles after accept; without the macro → NONSEQ with HADDR_o=0x42.
- Stream 16 back-to-back word writes to a zero-wait slave → req_ready held at 1, 16 consecutive NONSEQ cycles, 16 rsp pulses with rsp_err=0.
